// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, single-entry output slot with stall
// backpressure, branch redirect, halt and a sticky misaligned-redirect error.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        halt,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {FETCH, HALTED, ERROR} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        valid_nx, err_nx;
    logic [31:0] instr_nx, ipc_nx, ipc4_nx, cnt_nx;
    logic        slot_free, consumed, fire;

    assign imem_addr = pc;

    always_comb begin
        slot_free = !if_valid || !stall;
        consumed  = if_valid && !stall;
        // Gated by clr so no request is presented during a reset cycle.
        imem_req  = clr && (state == FETCH) && slot_free;
        fire      = imem_req && imem_ack;

        state_nx = state;
        pc_nx    = pc;
        valid_nx = if_valid;
        instr_nx = if_instr;
        ipc_nx   = if_pc;
        ipc4_nx  = if_pc4;
        err_nx   = fetch_err;
        cnt_nx   = fetch_cnt;

        if (consumed && fetch_cnt != 32'hFFFF_FFFF)
            cnt_nx = fetch_cnt + 32'd1;

        // ERROR is terminal until reset, so redirects are ignored there.
        if (br_valid && state != ERROR) begin
            valid_nx = 1'b0;
            if (br_target[1:0] == 2'b00) begin
                pc_nx    = br_target;
                state_nx = FETCH;
            end else begin
                state_nx = ERROR;
                err_nx   = 1'b1;
            end
        end else begin
            if (fire) begin
                valid_nx = 1'b1;
                instr_nx = imem_rdata;
                ipc_nx   = pc;
                ipc4_nx  = pc + 32'd4;
                pc_nx    = pc + 32'd4;
            end else if (consumed) begin
                valid_nx = 1'b0;
            end
            if (halt && state == FETCH)
                state_nx = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= 32'h0;
            if_pc     <= 32'h0;
            if_pc4    <= 32'h0;
            fetch_err <= 1'b0;
            fetch_cnt <= 32'h0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            if_valid  <= valid_nx;
            if_instr  <= instr_nx;
            if_pc     <= ipc_nx;
            if_pc4    <= ipc4_nx;
            fetch_err <= err_nx;
            fetch_cnt <= cnt_nx;
        end
    end

endmodule
